// File: rtl/ica_fx_pkg.sv
// ica_fx_pkg
//   Shared fixed-point definitions for the FastICA update datapath:
//   default word/fraction widths, the signed word typedef, the
//   nonlinearity mode encodings and a width-parametrised saturation
//   helper operating on a wide signed intermediate.
package ica_fx_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_DEF   = 12;

    // Width of every internal intermediate before clamping. Wide enough
    // for a DATA_W x DATA_W product plus guard bits for any sane SIZE_N.
    localparam int WIDE_W = 64;

    typedef logic signed [DATA_W_DEF-1:0] fx_t;

    localparam logic MODE_CUBIC  = 1'b0;
    localparam logic MODE_SQUARE = 1'b1;

    // Clamp v to the signed range of a w-bit word.
    function automatic logic signed [WIDE_W-1:0] fx_sat(
        input logic signed [WIDE_W-1:0] v,
        input int                       w
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        logic signed [WIDE_W-1:0] r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        r  = v;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/ica_nonlin.sv
// ica_nonlin
//   Combinational FastICA nonlinearity: from the projection u it produces
//   g(u) and g'(u). Every product is rescaled by >>> FRAC and clamped.
//   Ports:
//     u_i    in  DATA_W  projection w'x (signed fixed point)
//     mode_i in  1       MODE_CUBIC: g=u^3, g'=3u^2 ; MODE_SQUARE: g=u^2, g'=2u
//     g_o    out DATA_W  g(u)
//     gp_o   out DATA_W  g'(u)
module ica_nonlin
    import ica_fx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC   = FRAC_DEF
) (
    input  logic [DATA_W-1:0] u_i,
    input  logic              mode_i,
    output logic [DATA_W-1:0] g_o,
    output logic [DATA_W-1:0] gp_o
);

    logic signed [WIDE_W-1:0] u_w;
    logic signed [WIDE_W-1:0] u2_w;
    logic signed [WIDE_W-1:0] cube_w;

    always_comb begin
        u_w    = WIDE_W'($signed(u_i));
        u2_w   = fx_sat((u_w * u_w) >>> FRAC, DATA_W);
        cube_w = fx_sat((u2_w * u_w) >>> FRAC, DATA_W);
        g_o    = DATA_W'(u2_w);
        gp_o   = DATA_W'(fx_sat(64'sd2 * u_w, DATA_W));
        case (mode_i)
            MODE_CUBIC: begin
                g_o  = DATA_W'(cube_w);
                // 3 is an integer factor, not a fixed-point value: no rescale.
                gp_o = DATA_W'(fx_sat(64'sd3 * u2_w, DATA_W));
            end
            MODE_SQUARE: begin
                g_o  = DATA_W'(u2_w);
                gp_o = DATA_W'(fx_sat(64'sd2 * u_w, DATA_W));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ica_w_update_seq.sv
// ica_w_update_seq
//   Sequential fixed-point FastICA single-unit update:
//     w' = E{x g(w'x)} - E{g'(w'x)} w
//   over SIZE_M streamed observation columns of SIZE_N channels.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     start      begin an update (only honoured when idle)
//     mode       nonlinearity select, latched at start
//     w_in       current weight vector, channel n at [n*DATA_W +: DATA_W]
//     col_data   one observation column, same packing
//     col_valid  col_data valid
//     col_ready  a column is accepted this cycle if col_valid is high
//     w_out      updated weight vector, held until the next completion
//     busy       update in progress
//     valid      one-cycle pulse when w_out has just been updated
module ica_w_update_seq
    import ica_fx_pkg::*;
#(
    parameter int SIZE_N = 8,
    parameter int SIZE_M = 512,
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC   = FRAC_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic [SIZE_N*DATA_W-1:0] w_in,
    input  logic [SIZE_N*DATA_W-1:0] col_data,
    input  logic                     col_valid,
    output logic                     col_ready,
    output logic [SIZE_N*DATA_W-1:0] w_out,
    output logic                     busy,
    output logic                     valid
);

    localparam int LOG_M = $clog2(SIZE_M);
    localparam int ACC_W = DATA_W + LOG_M + 1;

    if (SIZE_M < 2 || (SIZE_M & (SIZE_M - 1)) != 0) begin : g_bad_size_m
        $error("ica_w_update_seq: SIZE_M must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DOT,
        S_NONLIN,
        S_ACCUM,
        S_MEAN,
        S_SUB,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q;
    logic [DATA_W-1:0] w_q     [SIZE_N];
    logic [DATA_W-1:0] x_q     [SIZE_N];
    logic [ACC_W-1:0]  acc_a_q [SIZE_N];
    logic [DATA_W-1:0] m_a_q   [SIZE_N];
    logic [DATA_W-1:0] wn_q    [SIZE_N];
    logic [DATA_W-1:0] w_out_q [SIZE_N];
    logic [DATA_W-1:0] u_q, g_q, gp_q, m_b_q;
    logic [ACC_W-1:0]  acc_b_q;
    logic [LOG_M-1:0]  cnt_q;
    logic              valid_q;

    logic [DATA_W-1:0]        u_d, g_d, gp_d;
    logic signed [WIDE_W-1:0] dot_sum;
    logic                     last_col;

    assign last_col = (cnt_q == LOG_M'(SIZE_M - 1));

    // Next state and status outputs.
    always_comb begin
        state_d   = state_q;
        col_ready = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:   if (start) state_d = S_WAIT;
            S_WAIT: begin
                col_ready = 1'b1;
                if (col_valid) state_d = S_DOT;
            end
            S_DOT:    state_d = S_NONLIN;
            S_NONLIN: state_d = S_ACCUM;
            S_ACCUM:  state_d = last_col ? S_MEAN : S_WAIT;
            S_MEAN:   state_d = S_SUB;
            S_SUB:    state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Projection u = sat(sum w*x >>> FRAC); the wide sum leaves ample guard bits.
    always_comb begin
        dot_sum = '0;
        for (int n = 0; n < SIZE_N; n++) begin
            dot_sum = dot_sum + WIDE_W'($signed(w_q[n])) * WIDE_W'($signed(x_q[n]));
        end
        u_d = DATA_W'(fx_sat(dot_sum >>> FRAC, DATA_W));
    end

    ica_nonlin #(
        .DATA_W (DATA_W),
        .FRAC   (FRAC)
    ) u_nonlin (
        .u_i    (u_q),
        .mode_i (mode_q),
        .g_o    (g_d),
        .gp_o   (gp_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_CUBIC;
            u_q     <= '0;
            g_q     <= '0;
            gp_q    <= '0;
            acc_b_q <= '0;
            m_b_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: if (start) begin
                    mode_q  <= mode;
                    acc_b_q <= '0;
                    cnt_q   <= '0;
                end
                S_DOT:    u_q <= u_d;
                S_NONLIN: begin
                    g_q  <= g_d;
                    gp_q <= gp_d;
                end
                S_ACCUM: begin
                    acc_b_q <= acc_b_q + ACC_W'($signed(gp_q));
                    cnt_q   <= cnt_q + LOG_M'(1);
                end
                S_MEAN: m_b_q <= DATA_W'(fx_sat(WIDE_W'($signed(acc_b_q)) >>> LOG_M, DATA_W));
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < SIZE_N; gi++) begin : g_ch
        logic [DATA_W-1:0]        term_d;
        logic [DATA_W-1:0]        m_a_d;
        logic [DATA_W-1:0]        wn_d;
        logic signed [WIDE_W-1:0] mbw;

        always_comb begin
            // The per-column term is clamped to a word, so SIZE_M of them
            // always fit in ACC_W without wrapping.
            term_d = DATA_W'(fx_sat((WIDE_W'($signed(x_q[gi])) * WIDE_W'($signed(g_q))) >>> FRAC,
                                    DATA_W));
            m_a_d  = DATA_W'(fx_sat(WIDE_W'($signed(acc_a_q[gi])) >>> LOG_M, DATA_W));
            mbw    = fx_sat((WIDE_W'($signed(m_b_q)) * WIDE_W'($signed(w_q[gi]))) >>> FRAC, DATA_W);
            wn_d   = DATA_W'(fx_sat(WIDE_W'($signed(m_a_q[gi])) - mbw, DATA_W));
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                w_q[gi]     <= '0;
                x_q[gi]     <= '0;
                acc_a_q[gi] <= '0;
                m_a_q[gi]   <= '0;
                wn_q[gi]    <= '0;
                w_out_q[gi] <= '0;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        w_q[gi]     <= w_in[gi*DATA_W +: DATA_W];
                        acc_a_q[gi] <= '0;
                    end
                    S_WAIT:  if (col_valid) x_q[gi] <= col_data[gi*DATA_W +: DATA_W];
                    S_ACCUM: acc_a_q[gi] <= acc_a_q[gi] + ACC_W'($signed(term_d));
                    S_MEAN:  m_a_q[gi] <= m_a_d;
                    S_SUB:   wn_q[gi] <= wn_d;
                    S_DONE:  w_out_q[gi] <= wn_q[gi];
                    default: ;
                endcase
            end
        end

        assign w_out[gi*DATA_W +: DATA_W] = w_out_q[gi];
    end

    assign valid = valid_q;

endmodule

// File: tb/tb_ica_w_update_seq.sv
// Testbench for ica_w_update_seq (SIZE_N=2, SIZE_M=4, DATA_W=16, FRAC=12).
// Directed cases plus randomized updates checked against an arithmetic
// reference model of the update rule.
module tb_ica_w_update_seq;

    localparam int N    = 2;
    localparam int M    = 4;
    localparam int DW   = 16;
    localparam int FR   = 12;
    localparam int LOGM = 2;

    logic          clk = 1'b0;
    logic          rst, start, mode, col_valid, col_ready, busy, valid;
    logic [N*DW-1:0] w_in, col_data, w_out;

    always #5 clk = ~clk;

    ica_w_update_seq #(
        .SIZE_N (N),
        .SIZE_M (M),
        .DATA_W (DW),
        .FRAC   (FR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .w_in      (w_in),
        .col_data  (col_data),
        .col_valid (col_valid),
        .col_ready (col_ready),
        .w_out     (w_out),
        .busy      (busy),
        .valid     (valid)
    );

    int     n_checks = 0;
    int     n_errors = 0;
    longint tb_w [N];
    longint tb_x [M][N];
    int     tb_gap [M];
    bit     tb_mode;
    longint exp_w [N];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat16(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // floor(v / 2^s)
    function automatic longint fdiv(longint v, int s);
        longint d, q;
        d = longint'(1) << s;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    // Reference: averages of x*g(u) and g'(u) over the columns, then w' = E1 - E2*w.
    function automatic void run_model();
        longint sa [N];
        longint sb, dot, u, u2, g, gp, ma, mb;
        for (int n = 0; n < N; n++) sa[n] = 0;
        sb = 0;
        for (int c = 0; c < M; c++) begin
            dot = 0;
            for (int n = 0; n < N; n++) dot += tb_w[n] * tb_x[c][n];
            u  = sat16(fdiv(dot, FR));
            u2 = sat16(fdiv(u * u, FR));
            if (tb_mode == 1'b0) begin
                g  = sat16(fdiv(u2 * u, FR));
                gp = sat16(3 * u2);
            end else begin
                g  = u2;
                gp = sat16(2 * u);
            end
            for (int n = 0; n < N; n++) sa[n] += sat16(fdiv(tb_x[c][n] * g, FR));
            sb += gp;
        end
        mb = sat16(fdiv(sb, LOGM));
        for (int n = 0; n < N; n++) begin
            ma       = sat16(fdiv(sa[n], LOGM));
            exp_w[n] = sat16(ma - sat16(fdiv(mb * tb_w[n], FR)));
        end
    endfunction

    function automatic logic [N*DW-1:0] pack_w();
        logic [N*DW-1:0] r;
        for (int n = 0; n < N; n++) r[n*DW +: DW] = DW'(tb_w[n]);
        return r;
    endfunction

    function automatic logic [N*DW-1:0] pack_x(int c);
        logic [N*DW-1:0] r;
        for (int n = 0; n < N; n++) r[n*DW +: DW] = DW'(tb_x[c][n]);
        return r;
    endfunction

    function automatic logic [N*DW-1:0] rand_vec();
        logic [N*DW-1:0] r;
        for (int n = 0; n < N; n++) r[n*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    function automatic longint get_w(int n);
        return longint'($signed(w_out[n*DW +: DW]));
    endfunction

    function automatic longint rnd(int lim);
        return longint'($urandom_range(0, 2 * lim - 1)) - longint'(lim);
    endfunction

    task automatic set_dir(input bit md, input longint w0, input longint w1,
                           input longint x0, input longint x1, input int gap);
        tb_mode = md;
        tb_w[0] = w0;
        tb_w[1] = w1;
        for (int c = 0; c < M; c++) begin
            tb_x[c][0] = x0;
            tb_x[c][1] = x1;
            tb_gap[c]  = gap;
        end
    endtask

    // One full update. glitch_cyc: cycle in which start is pulsed with other
    // w_in/mode (-1 = never). abort_after: assert rst after that many accepts.
    task automatic run_update(input string tag, input int glitch_cyc, input int abort_after);
        int cyc, col, gap_left, accepts, lat_exp;
        bit seen, acc;
        lat_exp = 4 * M + 4;
        for (int k = 0; k < M; k++) lat_exp += tb_gap[k];
        start     = 1'b1;
        mode      = tb_mode;
        w_in      = pack_w();
        col_valid = 1'b0;
        col_data  = rand_vec();
        @(posedge clk); #1;
        start    = 1'b0;
        mode     = 1'($urandom);
        w_in     = rand_vec();
        cyc      = 1;
        col      = 0;
        gap_left = tb_gap[0];
        accepts  = 0;
        seen     = 1'b0;
        while (!seen && cyc <= lat_exp + 8) begin
            start = 1'b0;
            if (cyc == glitch_cyc) begin
                start = 1'b1;
                mode  = ~tb_mode;
                w_in  = '0;
                w_in[DW +: DW] = 16'd4096;
            end
            check($sformatf("%s_busy_c%0d", tag, cyc), longint'(busy), longint'(cyc < lat_exp));
            if (valid) begin
                seen = 1'b1;
            end else begin
                if (col_ready) begin
                    if (gap_left > 0) begin
                        col_valid = 1'b0;
                        gap_left--;
                    end else if (col < M) begin
                        col_valid = 1'b1;
                        col_data  = pack_x(col);
                    end else begin
                        col_valid = 1'b0;
                    end
                end else begin
                    col_valid = 1'($urandom);
                    col_data  = rand_vec();
                end
                acc = col_valid && col_ready;
                @(posedge clk); #1;
                cyc++;
                if (acc) begin
                    col++;
                    accepts++;
                    if (col < M) gap_left = tb_gap[col];
                end
                if (abort_after > 0 && accepts == abort_after) begin
                    rst       = 1'b1;
                    col_valid = 1'b0;
                    start     = 1'b0;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    check({tag, "_rst_ready"}, longint'(col_ready), 0);
                    check({tag, "_rst_busy"}, longint'(busy), 0);
                    check({tag, "_rst_valid"}, longint'(valid), 0);
                    for (int n = 0; n < N; n++) check({tag, "_rst_wout"}, get_w(n), 0);
                    @(posedge clk); #1;
                    check({tag, "_rst_idle"}, longint'(busy), 0);
                    check({tag, "_rst_novalid"}, longint'(valid), 0);
                    $display("%s: reset after %0d accepts, w_out=[%0d,%0d]",
                             tag, accepts, get_w(0), get_w(1));
                    return;
                end
            end
        end
        col_valid = 1'b0;
        start     = 1'b0;
        check({tag, "_valid_seen"}, longint'(seen), 1);
        check({tag, "_latency"}, cyc, lat_exp);
        for (int n = 0; n < N; n++) check($sformatf("%s_w%0d", tag, n), get_w(n), exp_w[n]);
        $display("%s: mode=%0d w=[%0d,%0d] w_out=[%0d,%0d] exp=[%0d,%0d] lat=%0d",
                 tag, tb_mode, tb_w[0], tb_w[1], get_w(0), get_w(1), exp_w[0], exp_w[1], cyc);
        @(posedge clk); #1;
        check({tag, "_valid_pulse"}, longint'(valid), 0);
        check({tag, "_busy_after"}, longint'(busy), 0);
        for (int n = 0; n < N; n++) check($sformatf("%s_hold%0d", tag, n), get_w(n), exp_w[n]);
    endtask

    initial begin
        int gl, lat;
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        col_valid = 1'b0;
        w_in      = '0;
        col_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ready", longint'(col_ready), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_valid", longint'(valid), 0);
        for (int n = 0; n < N; n++) check("reset_wout", get_w(n), 0);
        @(posedge clk); #1;

        set_dir(1'b0, 4096, 0, 4096, 0, 0);
        exp_w[0] = -8192; exp_w[1] = 0;
        run_update("cubic", -1, 0);

        set_dir(1'b1, 4096, 0, 4096, 0, 0);
        exp_w[0] = -4096; exp_w[1] = 0;
        run_update("square", -1, 0);

        set_dir(1'b0, 28672, 28672, 28672, 28672, 0);
        exp_w[0] = 0; exp_w[1] = 0;
        run_update("saturate", -1, 0);

        set_dir(1'b0, 4096, 0, 4096, 0, 3);
        exp_w[0] = -8192; exp_w[1] = 0;
        run_update("backpressure", -1, 0);

        set_dir(1'b0, 4096, 0, 4096, 0, 0);
        run_update("abort", -1, 2);
        exp_w[0] = -8192; exp_w[1] = 0;
        run_update("after_abort", -1, 0);

        run_update("start_ignored", 3, 0);

        for (int t = 0; t < 24; t++) begin
            int lim;
            lim     = ($urandom_range(0, 3) == 0) ? 32768 : 3000;
            tb_mode = 1'($urandom);
            for (int n = 0; n < N; n++) tb_w[n] = rnd(lim);
            for (int c = 0; c < M; c++) begin
                for (int n = 0; n < N; n++) tb_x[c][n] = rnd(lim);
                tb_gap[c] = $urandom_range(0, 2);
            end
            run_model();
            lat = 4 * M + 4;
            for (int c = 0; c < M; c++) lat += tb_gap[c];
            case ($urandom_range(0, 3))
                0:       gl = -1;
                1:       gl = 3;
                2:       gl = lat - 1;
                default: gl = $urandom_range(2, 4 * M);
            endcase
            run_update($sformatf("rand%0d", t), gl, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
